complex_row_vector_feeder: RTL and testbench

Upstream sequencer for complex_row_by_vector_with_control. It walks a complex matrix row by row, one chunk at a time, and reads each matrix chunk with the matching vector chunk from two synchronous-read memories. Each chunk holds NO_OF_UNITS complex entries. It presents each chunk as packed a/p operands with a start_row_by_vector pulse and drives number_of_multiples. It zero-pads the final partial chunk of each row so padded lanes contribute 0 to the dot product.

---
 rtl/complex_pkg.sv | 27 ++
 rtl/complex_chunk_addr_gen.sv | 58 +++++
 rtl/complex_row_vector_feeder.sv | 158 +++++++++++++++
 tb/tb_complex_row_vector_feeder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_pkg.sv
// Shared constants, sizing helpers and the feeder state encoding for the complex
// row-by-vector datapath.
package complex_pkg;

    localparam int unsigned ENTRY_W = 64;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Never returns 0 so that derived vector widths stay legal for degenerate sizes.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/complex_chunk_addr_gen.sv
// Row/chunk walker: steps through the matrix one chunk per advance and exposes the
// linear matrix address plus end-of-row / end-of-matrix flags.
module complex_chunk_addr_gen #(
    parameter int unsigned CHUNKS   = 3,
    parameter int unsigned NUM_ROWS = 2,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned CHUNK_W  = 2,
    parameter int unsigned ROW_W    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [ADDR_W-1:0]  mat_addr,
    output logic [CHUNK_W-1:0] chunk,
    output logic [ROW_W-1:0]   row,
    output logic               last_chunk,
    output logic               last_row
);

    logic [ADDR_W-1:0]  addr_q;
    logic [CHUNK_W-1:0] chunk_q;
    logic [ROW_W-1:0]   row_q;

    assign mat_addr   = addr_q;
    assign chunk      = chunk_q;
    assign row        = row_q;
    assign last_chunk = (chunk_q == CHUNK_W'(CHUNKS - 1));
    assign last_row   = (row_q == ROW_W'(NUM_ROWS - 1));

    // A running linear address avoids a row*CHUNKS multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            chunk_q <= '0;
            row_q   <= '0;
        end else if (clear) begin
            addr_q  <= '0;
            chunk_q <= '0;
            row_q   <= '0;
        end else if (advance) begin
            if (last_chunk) begin
                chunk_q <= '0;
                if (last_row) begin
                    row_q  <= '0;
                    addr_q <= '0;
                end else begin
                    row_q  <= row_q + ROW_W'(1);
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end else begin
                chunk_q <= chunk_q + CHUNK_W'(1);
                addr_q  <= addr_q + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/complex_row_vector_feeder.sv
// Reads matrix/vector chunks from two synchronous memories and presents them, zero-padded
// at row ends, as operands for complex_row_by_vector_with_control.
module complex_row_vector_feeder
    import complex_pkg::*;
#(
    parameter int unsigned NO_OF_UNITS = 3,
    parameter int unsigned ENTRY_W     = complex_pkg::ENTRY_W,
    parameter int unsigned ROW_LEN     = 24,
    parameter int unsigned NUM_ROWS    = 24,
    localparam int unsigned CHUNKS     = ceil_div(ROW_LEN, NO_OF_UNITS),
    localparam int unsigned ADDR_W     = clog2(NUM_ROWS * CHUNKS),
    localparam int unsigned CNT_W      = clog2(CHUNKS + 1),
    localparam int unsigned VADDR_W    = clog2(CHUNKS),
    localparam int unsigned ROW_W      = clog2(NUM_ROWS),
    localparam int unsigned DATA_W     = NO_OF_UNITS * ENTRY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               hold,
    output logic [ADDR_W-1:0]  mat_addr,
    output logic               mat_rd_en,
    input  logic [DATA_W-1:0]  mat_rdata,
    output logic [VADDR_W-1:0] vec_addr,
    output logic               vec_rd_en,
    input  logic [DATA_W-1:0]  vec_rdata,
    output logic [DATA_W-1:0]  a,
    output logic [DATA_W-1:0]  p,
    output logic               start_row_by_vector,
    output logic [CNT_W-1:0]   number_of_multiples,
    output logic               last_chunk,
    output logic [ROW_W-1:0]   row_index,
    output logic               busy,
    output logic               done
);

    localparam int unsigned LAST_BASE = (CHUNKS - 1) * NO_OF_UNITS;

    feeder_state_e state_q, state_d;
    logic issue, clear;

    logic [VADDR_W-1:0] chunk_w;
    logic [ROW_W-1:0]   row_w;
    logic               last_chunk_w, last_row_w;

    // Tag pipe: stage 1 travels with the memory read, stage 2 with the registered operands.
    logic               v1_q, last1_q, start_q, last_q;
    logic [ROW_W-1:0]   row1_q, row_q;
    logic [DATA_W-1:0]  a_q, p_q, a_in, p_in;

    complex_chunk_addr_gen #(
        .CHUNKS   (CHUNKS),
        .NUM_ROWS (NUM_ROWS),
        .ADDR_W   (ADDR_W),
        .CHUNK_W  (VADDR_W),
        .ROW_W    (ROW_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .advance    (issue),
        .mat_addr   (mat_addr),
        .chunk      (chunk_w),
        .row        (row_w),
        .last_chunk (last_chunk_w),
        .last_row   (last_row_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        clear   = 1'b0;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StIssue;
                    clear   = 1'b1;
                end
            end
            StIssue: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (last_chunk_w && last_row_w) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Stage 1 empty means the final chunk is being presented right now.
                if (!v1_q) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle) && !done;
    assign mat_rd_en = issue;
    assign vec_rd_en = issue;
    assign vec_addr  = chunk_w;

    // Lanes past the end of the row on the final chunk are forced to zero.
    always_comb begin
        a_in = mat_rdata;
        p_in = vec_rdata;
        for (int k = 0; k < int'(NO_OF_UNITS); k++) begin
            if (last1_q && (LAST_BASE + k >= ROW_LEN)) begin
                a_in[(int'(NO_OF_UNITS) - k) * int'(ENTRY_W) - 1 -: ENTRY_W] = '0;
                p_in[(int'(NO_OF_UNITS) - k) * int'(ENTRY_W) - 1 -: ENTRY_W] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            row1_q  <= '0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            row_q   <= '0;
            a_q     <= '0;
            p_q     <= '0;
        end else begin
            v1_q    <= issue;
            start_q <= v1_q;
            if (issue) begin
                row1_q  <= row_w;
                last1_q <= last_chunk_w;
            end
            if (v1_q) begin
                a_q    <= a_in;
                p_q    <= p_in;
                row_q  <= row1_q;
                last_q <= last1_q;
            end
        end
    end

    assign a                   = a_q;
    assign p                   = p_q;
    assign start_row_by_vector = start_q;
    assign last_chunk          = start_q && last_q;
    assign row_index           = row_q;
    assign number_of_multiples = CNT_W'(CHUNKS);

endmodule

// File: tb/tb_complex_row_vector_feeder.sv
// Bench for complex_row_vector_feeder: a small 2x7 instance for timing/padding/hold/reset
// sequences and a full 24x24 instance for the long pass.
module tb_complex_row_vector_feeder;

    localparam int SN = 3, SLEN = 7, SROWS = 2, SCH = 3;
    localparam int BCH = 8, BROWS = 24;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Small instance
    logic         s_go = 1'b0, s_hold = 1'b0;
    logic [2:0]   s_mat_addr;
    logic [1:0]   s_vec_addr;
    logic         s_mat_rd_en, s_vec_rd_en, s_start, s_last, s_busy, s_done;
    logic [191:0] s_mat_rdata = '0, s_vec_rdata = '0, s_a, s_p;
    logic [1:0]   s_nom;
    logic [0:0]   s_row;

    // Big instance
    logic         b_go = 1'b0, b_hold = 1'b0;
    logic [7:0]   b_mat_addr;
    logic [2:0]   b_vec_addr;
    logic         b_mat_rd_en, b_vec_rd_en, b_start, b_last, b_busy, b_done;
    logic [191:0] b_mat_rdata = '0, b_vec_rdata = '0, b_a, b_p;
    logic [3:0]   b_nom;
    logic [4:0]   b_row;

    complex_row_vector_feeder #(
        .NO_OF_UNITS (SN),
        .ROW_LEN     (SLEN),
        .NUM_ROWS    (SROWS)
    ) u_small (
        .clk                 (clk),
        .reset               (reset),
        .go                  (s_go),
        .hold                (s_hold),
        .mat_addr            (s_mat_addr),
        .mat_rd_en           (s_mat_rd_en),
        .mat_rdata           (s_mat_rdata),
        .vec_addr            (s_vec_addr),
        .vec_rd_en           (s_vec_rd_en),
        .vec_rdata           (s_vec_rdata),
        .a                   (s_a),
        .p                   (s_p),
        .start_row_by_vector (s_start),
        .number_of_multiples (s_nom),
        .last_chunk          (s_last),
        .row_index           (s_row),
        .busy                (s_busy),
        .done                (s_done)
    );

    complex_row_vector_feeder #(
        .NO_OF_UNITS (3),
        .ROW_LEN     (24),
        .NUM_ROWS    (BROWS)
    ) u_big (
        .clk                 (clk),
        .reset               (reset),
        .go                  (b_go),
        .hold                (b_hold),
        .mat_addr            (b_mat_addr),
        .mat_rd_en           (b_mat_rd_en),
        .mat_rdata           (b_mat_rdata),
        .vec_addr            (b_vec_addr),
        .vec_rd_en           (b_vec_rd_en),
        .vec_rdata           (b_vec_rdata),
        .a                   (b_a),
        .p                   (b_p),
        .start_row_by_vector (b_start),
        .number_of_multiples (b_nom),
        .last_chunk          (b_last),
        .row_index           (b_row),
        .busy                (b_busy),
        .done                (b_done)
    );

    // Memory contents and synchronous-read models
    logic [191:0] mat_s [0:5];
    logic [191:0] vec_s [0:2];
    logic [191:0] mat_b [0:191];
    logic [191:0] vec_b [0:7];

    always @(posedge clk) begin
        if (s_mat_rd_en) s_mat_rdata <= mat_s[s_mat_addr];
        if (s_vec_rd_en) s_vec_rdata <= vec_s[s_vec_addr];
        if (b_mat_rd_en) b_mat_rdata <= mat_b[b_mat_addr];
        if (b_vec_rd_en) b_vec_rdata <= vec_b[b_vec_addr];
    end

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [191:0] rnd_word;
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: lane k of chunk c is a real entry only while c*SN+k < SLEN.
    function automatic logic [191:0] pad(input logic [191:0] w, input int c);
        logic [191:0] r;
        r = w;
        for (int k = 0; k < SN; k++)
            if (c * SN + k >= SLEN) r[(SN - k) * 64 - 1 -: 64] = '0;
        return r;
    endfunction

    // Small-instance monitor: the n-th pulse of a pass must be row n/SCH, chunk n%SCH.
    int mon_idx = 0, s_pulses = 0;
    bit ones_mode = 1'b0;
    always @(negedge clk) begin
        if (s_start) begin
            int r, c;
            r = mon_idx / SCH;
            c = mon_idx % SCH;
            check("pulse_in_range", 256'(mon_idx < SROWS * SCH), 256'(1));
            if (mon_idx < SROWS * SCH) begin
                check("mon_a", s_a, pad(mat_s[r * SCH + c], c));
                check("mon_p", s_p, pad(vec_s[c], c));
                check("mon_row", s_row, r);
                check("mon_last", s_last, c == SCH - 1);
            end
            if (ones_mode && s_last) begin
                check("ones_a_low", s_a[127:0], '0);
                check("ones_p_low", s_p[127:0], '0);
                check("ones_a_top", s_a[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
            end
            if (ones_mode && !s_last) check("ones_full", s_a, {192{1'b1}});
            mon_idx++;
            s_pulses++;
        end
    end

    int b_pulses = 0, b_bad = 0;
    always @(negedge clk) begin
        if (b_start) begin
            if (b_row !== 5'(b_pulses / BCH) || b_last !== (b_pulses % BCH == BCH - 1) ||
                b_a !== mat_b[b_pulses] || b_p !== vec_b[b_pulses % BCH]) b_bad++;
            b_pulses++;
        end
    end

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (s_done) seen = 1'b1;
            else tick();
        end
        check("done_within_budget", seen, 1);
        if (seen) tick();
    endtask

    typedef struct {
        logic       go;
        logic       rd;
        logic [2:0] addr;
        logic [1:0] vaddr;
        logic       st;
        logic       row;
        logic       last;
        logic       busy;
        logic       done;
    } vec_t;

    function automatic vec_t mk(logic go, logic rd, logic [2:0] addr, logic [1:0] vaddr,
                                logic st, logic row, logic last, logic busy, logic done);
        vec_t v;
        v.go = go; v.rd = rd; v.addr = addr; v.vaddr = vaddr; v.st = st;
        v.row = row; v.last = last; v.busy = busy; v.done = done;
        return v;
    endfunction

    vec_t tbl [10];
    logic st_h [0:20], rd_h [0:20], dn_h [0:20];

    initial begin
        // Cycle 0 drives go; go at cycle 4 (busy) and cycle 8 (done) must be ignored.
        tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[2] = mk(0, 1, 1, 1, 0, 0, 0, 1, 0);
        tbl[3] = mk(0, 1, 2, 2, 1, 0, 0, 1, 0);
        tbl[4] = mk(1, 1, 3, 0, 1, 0, 0, 1, 0);
        tbl[5] = mk(0, 1, 4, 1, 1, 0, 1, 1, 0);
        tbl[6] = mk(0, 1, 5, 2, 1, 1, 0, 1, 0);
        tbl[7] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0);
        tbl[8] = mk(1, 0, 0, 0, 1, 1, 1, 0, 1);
        tbl[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) mat_s[i] = rnd_word();
        for (int i = 0; i < 3; i++) vec_s[i] = rnd_word();
        for (int i = 0; i < 192; i++) mat_b[i] = rnd_word();
        for (int i = 0; i < 8; i++) vec_b[i] = rnd_word();

        reset = 1'b1;
        tick();
        tick();
        check("rst_nom_small", s_nom, 3);
        check("rst_nom_big", b_nom, 8);
        check("rst_busy", s_busy, 0);
        check("rst_a", s_a, '0);
        check("rst_addr", s_mat_addr, 0);
        reset = 1'b0;
        tick();

        // Basic pass, timing and go-ignore via the table
        mon_idx = 0;
        s_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            s_go = tbl[i].go;
            @(negedge clk);
            check($sformatf("tbl%0d_rd", i), s_mat_rd_en, tbl[i].rd);
            check($sformatf("tbl%0d_vrd", i), s_vec_rd_en, tbl[i].rd);
            check($sformatf("tbl%0d_start", i), s_start, tbl[i].st);
            check($sformatf("tbl%0d_busy", i), s_busy, tbl[i].busy);
            check($sformatf("tbl%0d_done", i), s_done, tbl[i].done);
            if (tbl[i].rd) begin
                check($sformatf("tbl%0d_addr", i), s_mat_addr, tbl[i].addr);
                check($sformatf("tbl%0d_vaddr", i), s_vec_addr, tbl[i].vaddr);
            end
            if (tbl[i].st) begin
                check($sformatf("tbl%0d_row", i), s_row, tbl[i].row);
                check($sformatf("tbl%0d_last", i), s_last, tbl[i].last);
            end
            tick();
        end
        check("pass1_pulses", s_pulses, 6);

        // go one cycle after done starts a new pass
        mon_idx = 0;
        s_pulses = 0;
        s_go = 1'b1;
        tick();
        s_go = 1'b0;
        @(negedge clk);
        check("rego_rd", s_mat_rd_en, 1);
        check("rego_addr", s_mat_addr, 0);
        check("rego_busy", s_busy, 1);
        tick();
        wait_done(20);
        check("pass2_pulses", s_pulses, 6);

        // All-ones memory: padded lanes must come out zero
        for (int i = 0; i < 6; i++) mat_s[i] = {192{1'b1}};
        for (int i = 0; i < 3; i++) vec_s[i] = {192{1'b1}};
        ones_mode = 1'b1;
        mon_idx = 0;
        s_pulses = 0;
        s_go = 1'b1;
        tick();
        s_go = 1'b0;
        wait_done(20);
        ones_mode = 1'b0;
        check("ones_pulses", s_pulses, 6);

        // hold for 5 cycles after 3 issues
        for (int i = 0; i < 6; i++) mat_s[i] = rnd_word();
        for (int i = 0; i < 3; i++) vec_s[i] = rnd_word();
        mon_idx = 0;
        s_pulses = 0;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            s_go = (cyc == 0);
            s_hold = (cyc >= 4 && cyc <= 8);
            @(negedge clk);
            st_h[cyc] = s_start;
            rd_h[cyc] = s_mat_rd_en;
            dn_h[cyc] = s_done;
            tick();
        end
        s_hold = 1'b0;
        begin
            int n_after, n_quiet, n_rd_hold, n_done;
            n_after = 0; n_quiet = 0; n_rd_hold = 0; n_done = 0;
            for (int c = 4; c <= 5; c++) n_after += int'(st_h[c]);
            for (int c = 6; c <= 10; c++) n_quiet += int'(st_h[c]);
            for (int c = 4; c <= 8; c++) n_rd_hold += int'(rd_h[c]);
            for (int c = 0; c <= 20; c++) n_done += int'(dn_h[c]);
            check("hold_inflight_pulses", n_after, 2);
            check("hold_quiet_pulses", n_quiet, 0);
            check("hold_resume_pulse", st_h[11], 1);
            check("hold_no_reads", n_rd_hold, 0);
            check("hold_resume_read", rd_h[9], 1);
            check("hold_done_count", n_done, 1);
            check("hold_pulses", s_pulses, 6);
        end

        // Asynchronous reset with reads in flight
        mon_idx = 0;
        s_pulses = 0;
        s_go = 1'b1;
        tick();
        s_go = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("arst_start", s_start, 0);
        check("arst_a", s_a, '0);
        check("arst_p", s_p, '0);
        check("arst_addr", s_mat_addr, 0);
        check("arst_rd", s_mat_rd_en, 0);
        check("arst_busy", s_busy, 0);
        tick();
        tick();
        reset = 1'b0;
        begin
            int n_st, n_busy;
            n_st = 0; n_busy = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                n_st += int'(s_start);
                n_busy += int'(s_busy);
                tick();
            end
            check("arst_no_pulse", n_st, 0);
            check("arst_idle", n_busy, 0);
        end
        mon_idx = 0;
        s_pulses = 0;
        s_go = 1'b1;
        tick();
        s_go = 1'b0;
        @(negedge clk);
        check("arst_restart_rd", s_mat_rd_en, 1);
        check("arst_restart_addr", s_mat_addr, 0);
        tick();
        wait_done(20);
        check("arst_restart_pulses", s_pulses, 6);

        // Full-size pass
        b_go = 1'b1;
        tick();
        b_go = 1'b0;
        begin
            int dcnt, blow, nbad;
            bit seen;
            dcnt = 0; blow = 0; nbad = 0; seen = 1'b0;
            for (int cyc = 0; cyc < 210; cyc++) begin
                @(negedge clk);
                if (b_done) begin
                    dcnt++;
                    seen = 1'b1;
                end else if (!seen && !b_busy) begin
                    blow++;
                end
                if (b_nom !== 4'd8) nbad++;
                tick();
            end
            check("big_pulses", b_pulses, 192);
            check("big_data_row_last", b_bad, 0);
            check("big_done_once", dcnt, 1);
            check("big_busy_throughout", blow, 0);
            check("big_nom_const", nbad, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
